demo_transmitter: RTL

DEMO_TRANSMITTER -- requirements
Module: demo_transmitter

---
 rtl/demo_transmitter_if.sv | 25 ++
 rtl/demo_transmitter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/demo_transmitter_if.sv
// Byte-in / serial-out handshake bundle for demo_transmitter.
// The master offers bytes; the slave (the transmitter) drives the serial line and status.
interface demo_transmitter_if;
    logic [7:0] Data;
    logic       Valid;
    logic       Ready;
    logic       SerialOut;
    logic       Busy;

    modport master (
        output Data,
        output Valid,
        input  Ready,
        input  SerialOut,
        input  Busy
    );

    modport slave (
        input  Data,
        input  Valid,
        output Ready,
        output SerialOut,
        output Busy
    );
endinterface

// File: rtl/demo_transmitter.sv
// UART-style serializer: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Each bit lasts CLKS_PER_BIT clocks; SerialOut is registered and idles high.
module demo_transmitter #(
    parameter int CLKS_PER_BIT = 8,
    parameter int PARITY_EN    = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    demo_transmitter_if.slave    bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [2:0]       idx_q, idx_nxt;
    logic [7:0]       data_q, data_nxt;
    logic             par_q, par_nxt;
    logic             so_q, so_nxt;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            so_q    <= 1'b1;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
            data_q  <= data_nxt;
            par_q   <= par_nxt;
            so_q    <= so_nxt;
        end
    end

    // SerialOut is computed for the state being entered so the line changes on the bit boundary.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        idx_nxt   = idx_q;
        data_nxt  = data_q;
        par_nxt   = par_q;
        so_nxt    = so_q;

        case (state_q)
            IDLE: begin
                so_nxt = 1'b1;
                if (bus.Valid) begin
                    state_nxt = START;
                    cnt_nxt   = CNT_RELOAD;
                    idx_nxt   = '0;
                    data_nxt  = bus.Data;
                    par_nxt   = even_parity(bus.Data);
                    so_nxt    = 1'b0;
                end
            end

            START: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else begin
                    state_nxt = DATA;
                    cnt_nxt   = CNT_RELOAD;
                    idx_nxt   = '0;
                    so_nxt    = data_q[0];
                end
            end

            DATA: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else begin
                    cnt_nxt = CNT_RELOAD;
                    if (idx_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_nxt = PARITY;
                            so_nxt    = par_q;
                        end else begin
                            state_nxt = STOP;
                            so_nxt    = 1'b1;
                        end
                    end else begin
                        idx_nxt = idx_q + 3'd1;
                        so_nxt  = data_q[idx_q + 3'd1];
                    end
                end
            end

            PARITY: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else begin
                    state_nxt = STOP;
                    cnt_nxt   = CNT_RELOAD;
                    so_nxt    = 1'b1;
                end
            end

            STOP: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    so_nxt    = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                so_nxt    = 1'b1;
            end
        endcase
    end

    assign bus.SerialOut = so_q;
    assign bus.Ready     = (state_q == IDLE);
    assign bus.Busy      = (state_q != IDLE);

endmodule
